// File: rtl/hwpe_cfg_master.sv
// hwpe_cfg_master: config-bus initiator with in-order response tracking.
// Issues single-word commands, checks response IDs, buffers responses.
module hwpe_cfg_master #(
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_wen_i,
  input  logic [AW-1:0]       cmd_add_i,
  input  logic [DW-1:0]       cmd_wdata_i,
  input  logic [DW/8-1:0]     cmd_be_i,
  output logic                req_o,
  output logic                wen_o,
  output logic [AW-1:0]       add_o,
  output logic [DW-1:0]       wdata_o,
  output logic [DW/8-1:0]     be_o,
  output logic [ID_WIDTH-1:0] id_o,
  input  logic                gnt_i,
  input  logic                r_valid_i,
  input  logic [DW-1:0]       r_rdata_i,
  input  logic [ID_WIDTH-1:0] r_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DW-1:0]       rsp_rdata_o,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  output logic                busy_o,
  output logic                err_o,
  input  logic                err_clear_i
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);
  localparam int unsigned OW = CW + 2;
  localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic                req_q, req_d;
  logic                wen_q, wen_d;
  logic [AW-1:0]       add_q, add_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [BW-1:0]       be_q, be_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] next_id_q, next_id_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       fcnt_q, fcnt_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                err_q, err_d;

  logic [MAX_OUTST-1:0][DW-1:0]       mem_data_q, mem_data_d;
  logic [MAX_OUTST-1:0][ID_WIDTH-1:0] mem_id_q, mem_id_d;

  logic [OW-1:0]       occ;
  logic [ID_WIDTH-1:0] exp_id;
  logic                cmd_fire, grant, rsp_ok, rsp_stray, id_bad, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts every credit in use: pending, in flight, buffered
  assign occ = OW'(req_q) + OW'(outst_q) + OW'(fcnt_q);
  assign cmd_ready_o = (!req_q || gnt_i) && (occ < OW'(MAX_OUTST));
  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign grant = req_q && gnt_i;
  // Oldest in-flight transaction is the one the next response must match
  assign exp_id = next_id_q - ID_WIDTH'(outst_q);
  assign rsp_ok = r_valid_i && (outst_q != '0);
  assign rsp_stray = r_valid_i && (outst_q == '0);
  assign id_bad = rsp_ok && (r_id_i != exp_id);
  assign pop = (fcnt_q != '0) && rsp_ready_i;

  assign req_o = req_q;
  assign wen_o = wen_q;
  assign add_o = add_q;
  assign wdata_o = wdata_q;
  assign be_o = be_q;
  assign id_o = id_q;
  assign rsp_valid_o = (fcnt_q != '0);
  assign rsp_rdata_o = mem_data_q[rd_ptr_q];
  assign rsp_id_o = mem_id_q[rd_ptr_q];
  assign busy_o = (occ != '0);
  assign err_o = err_q;

  // Next-state for request register, ID/credit counters, FIFO and error flag
  always_comb begin
    req_d = req_q;
    wen_d = wen_q;
    add_d = add_q;
    wdata_d = wdata_q;
    be_d = be_q;
    id_d = id_q;
    next_id_d = next_id_q;
    outst_d = outst_q;
    fcnt_d = fcnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_data_d = mem_data_q;
    mem_id_d = mem_id_q;
    err_d = err_q;

    if (grant) begin
      req_d = 1'b0;
      next_id_d = next_id_q + ID_WIDTH'(1);
    end
    // A command taken in the grant cycle gets the post-increment ID
    if (cmd_fire) begin
      req_d = 1'b1;
      wen_d = cmd_wen_i;
      add_d = cmd_add_i;
      wdata_d = cmd_wdata_i;
      be_d = cmd_be_i;
      id_d = next_id_d;
    end

    if (grant && !rsp_ok) begin
      outst_d = outst_q + CW'(1);
    end else if (!grant && rsp_ok) begin
      outst_d = outst_q - CW'(1);
    end

    if (rsp_ok) begin
      mem_data_d[wr_ptr_q] = r_rdata_i;
      mem_id_d[wr_ptr_q] = r_id_i;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (rsp_ok && !pop) begin
      fcnt_d = fcnt_q + CW'(1);
    end else if (!rsp_ok && pop) begin
      fcnt_d = fcnt_q - CW'(1);
    end

    if (rsp_stray || id_bad) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q <= 1'b0;
      wen_q <= 1'b1;
      add_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      id_q <= '0;
      next_id_q <= '0;
      outst_q <= '0;
      fcnt_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      mem_data_q <= '0;
      mem_id_q <= '0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      wen_q <= wen_d;
      add_q <= add_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      id_q <= id_d;
      next_id_q <= next_id_d;
      outst_q <= outst_d;
      fcnt_q <= fcnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_data_q <= mem_data_d;
      mem_id_q <= mem_id_d;
      err_q <= err_d;
    end
  end

endmodule
